spi_cmd_tx: RTL and testbench

SPI master that serialises one 408-bit (51-byte) command/parameter frame onto MOSI/SCLK/CS. Its wire format is the one consumed by the DMA_SPI receiver: MSB first, CPOL=0, data changes on SCLK falling edge, sampled on rising edge. It is used as the host-side model and loopback source that feeds command frames into the wcm/master_start chain.

---
 rtl/cmd_frame_pkg.sv | 70 +++++++
 rtl/spi_sclk_gen.sv | 42 ++++
 rtl/spi_cmd_tx.sv | 184 ++++++++++++++++++
 tb/tb_spi_cmd_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_frame_pkg.sv
// Command frame layout shared by the SPI transmitter and the DMA_SPI receiver.
package cmd_frame_pkg;

    localparam int FRAME_BITS = 408;
    localparam int CNT_W      = 16;
    localparam int BITCNT_W   = 9;

    localparam int TIME_W         = 64;
    localparam int TIME_MSB       = 407;
    localparam int FREQ_W         = 48;
    localparam int FREQ_MSB       = 343;
    localparam int FREQ_STEP_W    = 48;
    localparam int FREQ_STEP_MSB  = 295;
    localparam int FREQ_RATE_W    = 32;
    localparam int FREQ_RATE_MSB  = 247;
    localparam int TIME_START_W   = 64;
    localparam int TIME_START_MSB = 215;
    localparam int N_IMP_W        = 16;
    localparam int N_IMP_MSB      = 151;
    localparam int TYPE_IMP_W     = 8;
    localparam int TYPE_IMP_MSB   = 135;
    localparam int TI_W           = 32;
    localparam int TI_MSB         = 127;
    localparam int TP_W           = 32;
    localparam int TP_MSB         = 95;
    localparam int TBLANK1_W      = 32;
    localparam int TBLANK1_MSB    = 63;
    localparam int TBLANK2_W      = 32;
    localparam int TBLANK2_MSB    = 31;

    typedef struct packed {
        logic [TIME_W-1:0]       tm;
        logic [FREQ_W-1:0]       freq;
        logic [FREQ_STEP_W-1:0]  freq_step;
        logic [FREQ_RATE_W-1:0]  freq_rate;
        logic [TIME_START_W-1:0] time_start;
        logic [N_IMP_W-1:0]      n_impulse;
        logic [TYPE_IMP_W-1:0]   type_impulse;
        logic [TI_W-1:0]         interval_ti;
        logic [TP_W-1:0]         interval_tp;
        logic [TBLANK1_W-1:0]    tblank1;
        logic [TBLANK2_W-1:0]    tblank2;
    } cmd_frame_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } tx_state_t;

    function automatic logic [FRAME_BITS-1:0] pack_cmd_frame(input cmd_frame_t f);
        logic [FRAME_BITS-1:0] w;
        w = '0;
        w[TIME_MSB       -: TIME_W]       = f.tm;
        w[FREQ_MSB       -: FREQ_W]       = f.freq;
        w[FREQ_STEP_MSB  -: FREQ_STEP_W]  = f.freq_step;
        w[FREQ_RATE_MSB  -: FREQ_RATE_W]  = f.freq_rate;
        w[TIME_START_MSB -: TIME_START_W] = f.time_start;
        w[N_IMP_MSB      -: N_IMP_W]      = f.n_impulse;
        w[TYPE_IMP_MSB   -: TYPE_IMP_W]   = f.type_impulse;
        w[TI_MSB         -: TI_W]         = f.interval_ti;
        w[TP_MSB         -: TP_W]         = f.interval_tp;
        w[TBLANK1_MSB    -: TBLANK1_W]    = f.tblank1;
        w[TBLANK2_MSB    -: TBLANK2_W]    = f.tblank2;
        return w;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: CPOL=0 clock with CLK_DIV-cycle half periods and
// strobes flagging the CLK edge on which SCLK will rise or fall.
module spi_sclk_gen
    import cmd_frame_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sclk;
    logic             w_tick;

    assign w_tick = i_en && (r_cnt == CNT_W'(CLK_DIV - 1));
    assign o_rise = w_tick && !r_sclk;
    assign o_fall = w_tick && r_sclk;
    assign o_sclk = r_sclk;

    // Half-period counter; disabled or cleared forces SCLK low and restarts the low phase.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (!i_en || i_clr) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_tick) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_cmd_tx.sv
// SPI master sending one 408-bit command frame, MSB first, CPOL=0,
// data launched on SCLK fall and sampled by the receiver on SCLK rise.
module spi_cmd_tx
    import cmd_frame_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        ABORT,
    input  logic [63:0] TIME,
    input  logic [47:0] FREQ,
    input  logic [47:0] FREQ_STEP,
    input  logic [31:0] FREQ_RATE,
    input  logic [63:0] TIME_START,
    input  logic [15:0] N_impulse,
    input  logic [7:0]  TYPE_impulse,
    input  logic [31:0] Interval_Ti,
    input  logic [31:0] Interval_Tp,
    input  logic [31:0] Tblank1,
    input  logic [31:0] Tblank2,
    output logic        SCLK,
    output logic        MOSI,
    output logic        CS,
    output logic        BUSY,
    output logic        DONE,
    output logic        START_ERR
);

    tx_state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic [BITCNT_W-1:0]     r_bitcnt, w_bitcnt_nxt;
    logic [FRAME_BITS-1:0]   r_shift, w_shift_nxt;
    logic                    r_cs, w_cs_nxt;
    logic                    r_mosi, w_mosi_nxt;
    logic                    r_busy, w_busy_nxt;
    logic                    r_done, w_done_nxt;
    logic                    r_start_err, w_start_err_nxt;
    logic                    r_aborted, w_aborted_nxt;
    logic                    w_sclk_clr;
    logic                    w_sclk, w_rise, w_fall;
    cmd_frame_t              w_fields;
    logic [FRAME_BITS-1:0]   w_frame;

    assign w_fields = '{tm: TIME, freq: FREQ, freq_step: FREQ_STEP, freq_rate: FREQ_RATE,
                        time_start: TIME_START, n_impulse: N_impulse,
                        type_impulse: TYPE_impulse, interval_ti: Interval_Ti,
                        interval_tp: Interval_Tp, tblank1: Tblank1, tblank2: Tblank2};
    assign w_frame  = pack_cmd_frame(w_fields);

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .i_clk  (CLK),
        .i_rst  (RESET),
        .i_en   (r_state == ST_SHIFT),
        .i_clr  (w_sclk_clr),
        .o_sclk (w_sclk),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // State, counters, shift register and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_cs        <= 1'b1;
            r_mosi      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_shift     <= w_shift_nxt;
            r_cs        <= w_cs_nxt;
            r_mosi      <= w_mosi_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_start_err <= w_start_err_nxt;
            r_aborted   <= w_aborted_nxt;
        end
    end

    // Next-state and next-output logic; ABORT overrides the per-state behaviour.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bitcnt_nxt    = r_bitcnt;
        w_shift_nxt     = r_shift;
        w_cs_nxt        = r_cs;
        w_mosi_nxt      = r_mosi;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_start_err_nxt = START && (r_state != ST_IDLE);
        w_aborted_nxt   = r_aborted;
        w_sclk_clr      = 1'b0;

        if (ABORT && (r_state == ST_SETUP || r_state == ST_SHIFT || r_state == ST_HOLD)) begin
            w_state_nxt   = ST_GAP;
            w_cnt_nxt     = '0;
            w_bitcnt_nxt  = '0;
            w_cs_nxt      = 1'b1;
            w_mosi_nxt    = 1'b0;
            w_aborted_nxt = 1'b1;
            w_sclk_clr    = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        w_state_nxt   = ST_SETUP;
                        w_shift_nxt   = w_frame;
                        w_mosi_nxt    = w_frame[FRAME_BITS-1];
                        w_cs_nxt      = 1'b0;
                        w_busy_nxt    = 1'b1;
                        w_cnt_nxt     = '0;
                        w_bitcnt_nxt  = '0;
                        w_aborted_nxt = 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == CNT_W'(CS_SETUP - 1)) begin
                        w_state_nxt = ST_SHIFT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // Bits are counted on rises so the 408th fall is recognised directly.
                    if (w_fall) begin
                        w_shift_nxt = {r_shift[FRAME_BITS-2:0], 1'b0};
                        if (r_bitcnt == BITCNT_W'(FRAME_BITS)) begin
                            w_state_nxt  = ST_HOLD;
                            w_mosi_nxt   = 1'b0;
                            w_bitcnt_nxt = '0;
                            w_cnt_nxt    = '0;
                        end else begin
                            w_mosi_nxt   = r_shift[FRAME_BITS-2];
                        end
                    end else if (w_rise) begin
                        w_bitcnt_nxt = r_bitcnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == CNT_W'(CS_HOLD - 1)) begin
                        w_state_nxt = ST_GAP;
                        w_cs_nxt    = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == CNT_W'(CS_GAP - 1)) begin
                        w_state_nxt   = ST_IDLE;
                        w_cnt_nxt     = '0;
                        w_busy_nxt    = 1'b0;
                        w_done_nxt    = !r_aborted;
                        w_aborted_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt     = r_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign SCLK      = w_sclk;
    assign MOSI      = r_mosi;
    assign CS        = r_cs;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign START_ERR = r_start_err;

endmodule

// File: tb/tb_spi_cmd_tx.sv
// Directed bench for spi_cmd_tx: default timing instance and a fastest-timing instance.
module tb_spi_cmd_tx;
    import cmd_frame_pkg::*;

    typedef logic [407:0] vec_t;

    localparam vec_t DEF  = {64'h1, 48'h280000000000, 48'h00000002cbd3f, 32'd1, 64'd50000,
                             16'd10, 8'd0, 32'd100, 32'd100, 32'd10, 32'd5};
    localparam vec_t ONES = '1;
    localparam vec_t AA   = {51{8'hAA}};

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
    logic [63:0] f_time, f_tstart;
    logic [47:0] f_freq, f_fstep;
    logic [31:0] f_frate, f_ti, f_tp, f_tb1, f_tb2;
    logic [15:0] f_nimp;
    logic [7:0]  f_type;
    logic sclk0, mosi0, cs0, busy0, done0, err0;
    logic sclk1, mosi1, cs1, busy1, done1, err1;

    spi_cmd_tx #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4)) dut0 (
        .CLK(CLK), .RESET(RESET), .START(start0), .ABORT(abort0),
        .TIME(f_time), .FREQ(f_freq), .FREQ_STEP(f_fstep), .FREQ_RATE(f_frate),
        .TIME_START(f_tstart), .N_impulse(f_nimp), .TYPE_impulse(f_type),
        .Interval_Ti(f_ti), .Interval_Tp(f_tp), .Tblank1(f_tb1), .Tblank2(f_tb2),
        .SCLK(sclk0), .MOSI(mosi0), .CS(cs0), .BUSY(busy0), .DONE(done0), .START_ERR(err0)
    );

    spi_cmd_tx #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .START(start1), .ABORT(abort1),
        .TIME(f_time), .FREQ(f_freq), .FREQ_STEP(f_fstep), .FREQ_RATE(f_frate),
        .TIME_START(f_tstart), .N_impulse(f_nimp), .TYPE_impulse(f_type),
        .Interval_Ti(f_ti), .Interval_Tp(f_tp), .Tblank1(f_tb1), .Tblank2(f_tb2),
        .SCLK(sclk1), .MOSI(mosi1), .CS(cs1), .BUSY(busy1), .DONE(done1), .START_ERR(err1)
    );

    always #5 CLK = ~CLK;

    int   errors, checks, cyc;
    bit   mon_sel;
    int   cs_fall_cyc, cs_rise_cyc, first_rise_cyc, last_rise_cyc, busy_low_cyc, done_cyc;
    int   n_rise, n_done, n_err, bad_mosi, bad_per, per_exp;
    vec_t word;
    logic p_s, p_m, p_c, p_b;
    logic [5:0] c1_snap, rst_snap;
    logic [2:0] ab_snap;

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {CS, SCLK, MOSI, BUSY, DONE, START_ERR} of the selected instance
    function automatic logic [5:0] outs();
        if (mon_sel) return {cs1, sclk1, mosi1, busy1, done1, err1};
        return {cs0, sclk0, mosi0, busy0, done0, err0};
    endfunction

    task automatic drive(input logic s, input logic a);
        if (mon_sel) begin start1 = s; abort1 = a; end
        else begin start0 = s; abort0 = a; end
    endtask

    task automatic set_fields(input vec_t w);
        f_time = w[407:344]; f_freq = w[343:296]; f_fstep = w[295:248]; f_frate = w[247:216];
        f_tstart = w[215:152]; f_nimp = w[151:136]; f_type = w[135:128]; f_ti = w[127:96];
        f_tp = w[95:64]; f_tb1 = w[63:32]; f_tb2 = w[31:0];
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic mon_clear();
        logic [5:0] o;
        o = outs();
        cs_fall_cyc = -1; cs_rise_cyc = -1; first_rise_cyc = -1; last_rise_cyc = -1;
        busy_low_cyc = -1; done_cyc = -1;
        n_rise = 0; n_done = 0; n_err = 0; bad_mosi = 0; bad_per = 0;
        word = '0; c1_snap = 'x; rst_snap = 'x; ab_snap = 'x;
        p_c = o[5]; p_s = o[4]; p_m = o[3]; p_b = o[2];
    endtask

    task automatic sample();
        logic [5:0] o;
        logic s, m, c;
        o = outs();
        c = o[5]; s = o[4]; m = o[3];
        if (p_c && !c) cs_fall_cyc = cyc;
        if (!p_c && c) cs_rise_cyc = cyc;
        if (!p_s && s) begin
            n_rise++;
            if (n_rise == 1) first_rise_cyc = cyc;
            else if (cyc - last_rise_cyc != per_exp) bad_per++;
            last_rise_cyc = cyc;
            word = {word[406:0], m};
        end
        if ((m !== p_m) && !(p_s && !s) && (c === p_c)) bad_mosi++;
        if (p_b && !o[2]) busy_low_cyc = cyc;
        if (o[1]) begin n_done++; done_cyc = cyc; end
        if (o[0]) n_err++;
        p_c = c; p_s = s; p_m = m; p_b = o[2];
    endtask

    // One frame started at cycle 0; fields are scrambled from cycle 1 on.
    // Returns on DONE, on BUSY falling after an abort, after a reset hit, or at budget.
    task automatic run(input bit sel, input vec_t fr, input int abort_at, input int e1,
                       input int e2, input int rst_at, input int budget);
        logic [5:0] o;
        mon_sel = sel;
        per_exp = sel ? 2 : 4;
        cyc = 0;
        set_fields(fr);
        mon_clear();
        drive(1'b1, 1'b0);
        forever begin
            tick();
            sample();
            o = outs();
            if (cyc == 1) begin c1_snap = o; set_fields(~fr); end
            if (cyc == abort_at + 1) ab_snap = o[5:3];
            drive((cyc == e1) || (cyc == e2), cyc == abort_at);
            if (cyc == rst_at) begin
                #2 RESET = 1'b1;
                #1 rst_snap = outs();
                break;
            end
            if (n_done > 0) break;
            if (abort_at >= 0 && cyc > abort_at && !o[2]) break;
            if (cyc >= budget) break;
        end
        drive(1'b0, 1'b0);
        set_fields(fr);
    endtask

    task automatic full_frame_checks(input string tag, input vec_t fr);
        check({tag, "_word"}, word, fr);
        check({tag, "_rises"}, vec_t'(n_rise), vec_t'(408));
        check({tag, "_cs_fall"}, vec_t'(cs_fall_cyc), vec_t'(1));
        check({tag, "_done_cyc"}, vec_t'(done_cyc), vec_t'(1641));
        check({tag, "_n_done"}, vec_t'(n_done), vec_t'(1));
    endtask

    initial begin
        cmd_frame_t s;
        errors = 0; checks = 0; cyc = 0; mon_sel = 0; per_exp = 4;
        set_fields(DEF);
        repeat (3) @(posedge CLK);
        #1;
        check("reset_dut0", vec_t'(outs()), vec_t'(6'b100000));
        mon_sel = 1;
        check("reset_dut1", vec_t'(outs()), vec_t'(6'b100000));
        mon_sel = 0;
        RESET = 1'b0;
        tick(); tick();

        s.tm = 64'h1; s.freq = 48'h280000000000; s.freq_step = 48'h2cbd3f; s.freq_rate = 32'd1;
        s.time_start = 64'd50000; s.n_impulse = 16'd10; s.type_impulse = 8'd0;
        s.interval_ti = 32'd100; s.interval_tp = 32'd100; s.tblank1 = 32'd10; s.tblank2 = 32'd5;
        check("pack_fn", pack_cmd_frame(s), DEF);

        // Default frame, nominal timing
        run(0, DEF, -1, -1, -1, -1, 2000);
        full_frame_checks("def", DEF);
        check("def_cyc1", vec_t'(c1_snap), vec_t'(6'b000100));
        check("def_cs_rise", vec_t'(cs_rise_cyc), vec_t'(1637));
        check("def_first_rise", vec_t'(first_rise_cyc), vec_t'(5));
        check("def_busy_low", vec_t'(busy_low_cyc), vec_t'(1641));
        check("def_sclk_period", vec_t'(bad_per), vec_t'(0));
        check("def_mosi_on_fall", vec_t'(bad_mosi), vec_t'(0));
        check("def_no_err", vec_t'(n_err), vec_t'(0));
        check("rx_TIME", vec_t'(word[407:344]), vec_t'(64'h1));
        check("rx_FREQ", vec_t'(word[343:296]), vec_t'(48'h280000000000));
        check("rx_FREQ_STEP", vec_t'(word[295:248]), vec_t'(48'h2cbd3f));
        check("rx_FREQ_RATE", vec_t'(word[247:216]), vec_t'(32'd1));
        check("rx_TIME_START", vec_t'(word[215:152]), vec_t'(64'd50000));
        check("rx_N_impulse", vec_t'(word[151:136]), vec_t'(16'd10));
        check("rx_TYPE", vec_t'(word[135:128]), vec_t'(8'd0));
        check("rx_Ti", vec_t'(word[127:96]), vec_t'(32'd100));
        check("rx_Tp", vec_t'(word[95:64]), vec_t'(32'd100));
        check("rx_Tblank1", vec_t'(word[63:32]), vec_t'(32'd10));
        check("rx_Tblank2", vec_t'(word[31:0]), vec_t'(32'd5));
        tick(); tick();

        // START while busy, then START held in the DONE cycle
        run(0, DEF, -1, 10, 800, -1, 2000);
        full_frame_checks("err", DEF);
        check("err_pulses", vec_t'(n_err), vec_t'(2));
        drive(1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b1);
        check("chain_start", vec_t'(outs()), vec_t'(6'b000100));
        tick();
        drive(1'b0, 1'b0);
        check("chain_abort_cs", vec_t'(outs()), vec_t'(6'b100100));
        for (int i = 0; i < 20 && outs()[2]; i++) tick();
        check("chain_abort_idle", vec_t'(outs()), vec_t'(6'b100000));
        tick(); tick();

        // ABORT mid-shift, then a clean frame
        run(0, DEF, 400, -1, -1, -1, 2000);
        check("abort_cs_rise", vec_t'(cs_rise_cyc), vec_t'(401));
        check("abort_snap", vec_t'(ab_snap), vec_t'(3'b100));
        check("abort_busy_low", vec_t'(busy_low_cyc), vec_t'(405));
        check("abort_no_done", vec_t'(n_done), vec_t'(0));
        tick(); tick();
        run(0, DEF, -1, -1, -1, -1, 2000);
        full_frame_checks("post_abort", DEF);

        // Asynchronous reset mid-frame, then a clean frame
        tick(); tick();
        run(0, DEF, -1, -1, -1, 700, 2000);
        check("rst_async", vec_t'(rst_snap), vec_t'(6'b100000));
        tick();
        RESET = 1'b0;
        tick(); tick();
        run(0, DEF, -1, -1, -1, -1, 2000);
        full_frame_checks("post_rst", DEF);

        // Fastest timing instance: all-ones and alternating frames
        tick(); tick();
        run(1, ONES, -1, -1, -1, -1, 1000);
        check("fast1_word", word, ONES);
        check("fast1_cyc1", vec_t'(c1_snap), vec_t'(6'b001100));
        check("fast1_first_rise", vec_t'(first_rise_cyc), vec_t'(3));
        check("fast1_cs_rise", vec_t'(cs_rise_cyc), vec_t'(819));
        check("fast1_done_cyc", vec_t'(done_cyc), vec_t'(820));
        tick(); tick();
        run(1, AA, -1, -1, -1, -1, 1000);
        check("fastaa_word", word, AA);
        check("fastaa_rises", vec_t'(n_rise), vec_t'(408));
        check("fastaa_period", vec_t'(bad_per), vec_t'(0));
        check("fastaa_mosi_on_fall", vec_t'(bad_mosi), vec_t'(0));
        check("fastaa_cs_low", vec_t'(cs_rise_cyc - cs_fall_cyc), vec_t'(818));
        check("fastaa_done_cyc", vec_t'(done_cyc), vec_t'(820));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
